// File: rtl/axil_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axil_arb_pkg
// Brief   : Shared state and grant encodings for the 2:1 AXI-Lite arbiter.
// Rev     : 1.0
// ============================================================================
package axil_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rstate_t;

    typedef enum logic {
        GNT_S0 = 1'b0,
        GNT_S1 = 1'b1
    } gnt_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-requester round-robin picker with a registered tie-break pointer.
// Rev     : 1.0
// ============================================================================
module rr_arb2
    import axil_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    input  logic       i_served,
    output logic       o_winner
);

    // Pointer names the requester that wins the next tie; it flips away from
    // whoever was just served, so reset value GNT_S0 lets s0 win the first tie.
    gnt_t r_prio;
    logic w_winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= GNT_S0;
        end else if (i_advance) begin
            r_prio <= (i_served == GNT_S1) ? GNT_S0 : GNT_S1;
        end
    end

    always_comb begin
        w_winner = GNT_S0;
        case (i_req)
            2'b01:   w_winner = GNT_S0;
            2'b10:   w_winner = GNT_S1;
            2'b11:   w_winner = r_prio;
            default: w_winner = GNT_S0;
        endcase
    end

    assign o_winner = w_winner;

endmodule
`default_nettype wire

// File: rtl/axil_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module  : axil_arbiter_2to1
// Brief   : 2:1 AXI-Lite arbiter, independent round-robin write and read paths.
// Rev     : 1.0
// ============================================================================
module axil_arbiter_2to1
    import axil_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int STRB_WIDTH = DATA_WIDTH/8+1
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
    input  logic                  s0_axi_awvalid,
    output logic                  s0_axi_awready,
    input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axi_wstrb,
    input  logic                  s0_axi_wvalid,
    output logic                  s0_axi_wready,
    output logic [RESP_WIDTH-1:0] s0_axi_bresp,
    output logic                  s0_axi_bvalid,
    input  logic                  s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [RESP_WIDTH-1:0] s0_axi_rresp,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,
    input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
    input  logic                  s1_axi_awvalid,
    output logic                  s1_axi_awready,
    input  logic [DATA_WIDTH-1:0] s1_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s1_axi_wstrb,
    input  logic                  s1_axi_wvalid,
    output logic                  s1_axi_wready,
    output logic [RESP_WIDTH-1:0] s1_axi_bresp,
    output logic                  s1_axi_bvalid,
    input  logic                  s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [RESP_WIDTH-1:0] s1_axi_rresp,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,
    output logic [ADDR_WIDTH-1:0] m0_axi_awaddr,
    output logic                  m0_axi_awvalid,
    input  logic                  m0_axi_awready,
    output logic [DATA_WIDTH-1:0] m0_axi_wdata,
    output logic [STRB_WIDTH-1:0] m0_axi_wstrb,
    output logic                  m0_axi_wvalid,
    input  logic                  m0_axi_wready,
    input  logic [RESP_WIDTH-1:0] m0_axi_bresp,
    input  logic                  m0_axi_bvalid,
    output logic                  m0_axi_bready,
    output logic [ADDR_WIDTH-1:0] m0_axi_araddr,
    output logic                  m0_axi_arvalid,
    input  logic                  m0_axi_arready,
    input  logic [DATA_WIDTH-1:0] m0_axi_rdata,
    input  logic [RESP_WIDTH-1:0] m0_axi_rresp,
    input  logic                  m0_axi_rvalid,
    output logic                  m0_axi_rready
);

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;
    logic    r_wgnt, r_rgnt, r_aw_done, r_w_done;
    logic    w_wwin, w_rwin;
    logic    w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic    w_sel_bready, w_sel_rready;
    logic [1:0] w_wreq, w_rreq;

    assign w_wreq = {s1_axi_awvalid & s1_axi_wvalid, s0_axi_awvalid & s0_axi_wvalid};
    assign w_rreq = {s1_axi_arvalid, s0_axi_arvalid};

    assign w_sel_bready = (r_wgnt == GNT_S1) ? s1_axi_bready : s0_axi_bready;
    assign w_sel_rready = (r_rgnt == GNT_S1) ? s1_axi_rready : s0_axi_rready;

    assign w_aw_hs = m0_axi_awvalid & m0_axi_awready;
    assign w_w_hs  = m0_axi_wvalid & m0_axi_wready;
    assign w_b_hs  = m0_axi_bvalid & m0_axi_bready;
    assign w_ar_hs = m0_axi_arvalid & m0_axi_arready;
    assign w_r_hs  = m0_axi_rvalid & m0_axi_rready;

    rr_arb2 u_wr_arb (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .i_req     (w_wreq),
        .i_advance (w_b_hs),
        .i_served  (r_wgnt),
        .o_winner  (w_wwin)
    );

    rr_arb2 u_rd_arb (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .i_req     (w_rreq),
        .i_advance (w_r_hs),
        .i_served  (r_rgnt),
        .o_winner  (w_rwin)
    );

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_wstate  <= W_IDLE;
            r_rstate  <= R_IDLE;
            r_wgnt    <= GNT_S0;
            r_rgnt    <= GNT_S0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
            if (r_wstate == W_IDLE && |w_wreq) r_wgnt <= w_wwin;
            if (r_rstate == R_IDLE && |w_rreq) r_rgnt <= w_rwin;
            if (w_b_hs) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (|w_wreq) w_wstate_nxt = W_ADDR;
            W_ADDR:  if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (|w_rreq) w_rstate_nxt = R_ADDR;
            R_ADDR:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Payloads are forwarded only while granted so m0 stays quiet (zero) otherwise.
    always_comb begin
        m0_axi_awaddr  = '0;
        m0_axi_awvalid = 1'b0;
        m0_axi_wdata   = '0;
        m0_axi_wstrb   = '0;
        m0_axi_wvalid  = 1'b0;
        m0_axi_bready  = 1'b0;
        s0_axi_awready = 1'b0;
        s0_axi_wready  = 1'b0;
        s0_axi_bvalid  = 1'b0;
        s1_axi_awready = 1'b0;
        s1_axi_wready  = 1'b0;
        s1_axi_bvalid  = 1'b0;
        if (r_wstate == W_ADDR) begin
            if (r_wgnt == GNT_S1) begin
                m0_axi_awaddr  = s1_axi_awaddr;
                m0_axi_wdata   = s1_axi_wdata;
                m0_axi_wstrb   = s1_axi_wstrb;
                m0_axi_awvalid = s1_axi_awvalid & ~r_aw_done;
                m0_axi_wvalid  = s1_axi_wvalid & ~r_w_done;
                s1_axi_awready = m0_axi_awready & ~r_aw_done;
                s1_axi_wready  = m0_axi_wready & ~r_w_done;
            end else begin
                m0_axi_awaddr  = s0_axi_awaddr;
                m0_axi_wdata   = s0_axi_wdata;
                m0_axi_wstrb   = s0_axi_wstrb;
                m0_axi_awvalid = s0_axi_awvalid & ~r_aw_done;
                m0_axi_wvalid  = s0_axi_wvalid & ~r_w_done;
                s0_axi_awready = m0_axi_awready & ~r_aw_done;
                s0_axi_wready  = m0_axi_wready & ~r_w_done;
            end
        end
        if (r_wstate == W_RESP) begin
            m0_axi_bready = w_sel_bready;
            if (r_wgnt == GNT_S1) s1_axi_bvalid = m0_axi_bvalid;
            else                  s0_axi_bvalid = m0_axi_bvalid;
        end
    end

    always_comb begin
        m0_axi_araddr  = '0;
        m0_axi_arvalid = 1'b0;
        m0_axi_rready  = 1'b0;
        s0_axi_arready = 1'b0;
        s0_axi_rvalid  = 1'b0;
        s1_axi_arready = 1'b0;
        s1_axi_rvalid  = 1'b0;
        if (r_rstate == R_ADDR) begin
            if (r_rgnt == GNT_S1) begin
                m0_axi_araddr  = s1_axi_araddr;
                m0_axi_arvalid = s1_axi_arvalid;
                s1_axi_arready = m0_axi_arready;
            end else begin
                m0_axi_araddr  = s0_axi_araddr;
                m0_axi_arvalid = s0_axi_arvalid;
                s0_axi_arready = m0_axi_arready;
            end
        end
        if (r_rstate == R_DATA) begin
            m0_axi_rready = w_sel_rready;
            if (r_rgnt == GNT_S1) s1_axi_rvalid = m0_axi_rvalid;
            else                  s0_axi_rvalid = m0_axi_rvalid;
        end
    end

    assign s0_axi_bresp = m0_axi_bresp;
    assign s1_axi_bresp = m0_axi_bresp;
    assign s0_axi_rdata = m0_axi_rdata;
    assign s1_axi_rdata = m0_axi_rdata;
    assign s0_axi_rresp = m0_axi_rresp;
    assign s1_axi_rresp = m0_axi_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axil_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module  : tb_axil_arbiter_2to1
// Brief   : Directed self-checking bench for the 2:1 AXI-Lite arbiter.
// Rev     : 1.0
// ============================================================================
module tb_axil_arbiter_2to1;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 3;
    localparam int SW = DW/8+1;

    logic          axi_aclk = 1'b0;
    logic          axi_aresetn;
    logic [AW-1:0] s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
    logic          s0_axi_awvalid, s1_axi_awvalid, s0_axi_wvalid, s1_axi_wvalid;
    logic          s0_axi_awready, s1_axi_awready, s0_axi_wready, s1_axi_wready;
    logic [DW-1:0] s0_axi_wdata, s1_axi_wdata, s0_axi_rdata, s1_axi_rdata;
    logic [SW-1:0] s0_axi_wstrb, s1_axi_wstrb;
    logic [RW-1:0] s0_axi_bresp, s1_axi_bresp, s0_axi_rresp, s1_axi_rresp;
    logic          s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
    logic          s0_axi_arvalid, s1_axi_arvalid, s0_axi_arready, s1_axi_arready;
    logic          s0_axi_rvalid, s1_axi_rvalid, s0_axi_rready, s1_axi_rready;
    logic [AW-1:0] m0_axi_awaddr, m0_axi_araddr;
    logic          m0_axi_awvalid, m0_axi_awready, m0_axi_wvalid, m0_axi_wready;
    logic [DW-1:0] m0_axi_wdata, m0_axi_rdata;
    logic [SW-1:0] m0_axi_wstrb;
    logic [RW-1:0] m0_axi_bresp, m0_axi_rresp;
    logic          m0_axi_bvalid, m0_axi_bready, m0_axi_arvalid, m0_axi_arready;
    logic          m0_axi_rvalid, m0_axi_rready;

    int n_checks = 0;
    int n_fail   = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt  = 0;
    int aw_base, w_base;

    always #5 axi_aclk = ~axi_aclk;

    always @(posedge axi_aclk) begin
        if (m0_axi_awvalid && m0_axi_awready) aw_hs_cnt <= aw_hs_cnt + 1;
        if (m0_axi_wvalid && m0_axi_wready)   w_hs_cnt  <= w_hs_cnt + 1;
    end

    axil_arbiter_2to1 #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .STRB_WIDTH(SW)
    ) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
        .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wvalid(s0_axi_wvalid),
        .s0_axi_wready(s0_axi_wready), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
        .s0_axi_bready(s0_axi_bready), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arvalid(s0_axi_arvalid),
        .s0_axi_arready(s0_axi_arready), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
        .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
        .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
        .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wvalid(s1_axi_wvalid),
        .s1_axi_wready(s1_axi_wready), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
        .s1_axi_bready(s1_axi_bready), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arvalid(s1_axi_arvalid),
        .s1_axi_arready(s1_axi_arready), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
        .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
        .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(m0_axi_awready),
        .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb), .m0_axi_wvalid(m0_axi_wvalid),
        .m0_axi_wready(m0_axi_wready), .m0_axi_bresp(m0_axi_bresp), .m0_axi_bvalid(m0_axi_bvalid),
        .m0_axi_bready(m0_axi_bready), .m0_axi_araddr(m0_axi_araddr), .m0_axi_arvalid(m0_axi_arvalid),
        .m0_axi_arready(m0_axi_arready), .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp),
        .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m0_axi_rready)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        s0_axi_awaddr = '0; s0_axi_awvalid = 0; s0_axi_wdata = '0; s0_axi_wstrb = '0;
        s0_axi_wvalid = 0; s0_axi_bready = 0; s0_axi_araddr = '0; s0_axi_arvalid = 0; s0_axi_rready = 0;
        s1_axi_awaddr = '0; s1_axi_awvalid = 0; s1_axi_wdata = '0; s1_axi_wstrb = '0;
        s1_axi_wvalid = 0; s1_axi_bready = 0; s1_axi_araddr = '0; s1_axi_arvalid = 0; s1_axi_rready = 0;
        m0_axi_awready = 0; m0_axi_wready = 0; m0_axi_bresp = '0; m0_axi_bvalid = 0;
        m0_axi_arready = 0; m0_axi_rdata = '0; m0_axi_rresp = '0; m0_axi_rvalid = 0;
    endtask

    task automatic do_reset();
        @(negedge axi_aclk);
        clear_inputs();
        axi_aresetn = 1'b0;
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
    endtask

    // Called at a negedge in W_IDLE with both write requests raised.
    task automatic wr_contend(input logic win1, input logic [RW-1:0] resp);
        @(negedge axi_aclk);
        #1;
        check_eq("cont_awaddr", m0_axi_awaddr, win1 ? 8'h20 : 8'h10);
        check_eq("cont_awready_win", win1 ? s1_axi_awready : s0_axi_awready, 1);
        check_eq("cont_awready_lose", win1 ? s0_axi_awready : s1_axi_awready, 0);
        @(negedge axi_aclk);
        if (win1) begin s1_axi_awvalid = 0; s1_axi_wvalid = 0; end
        else      begin s0_axi_awvalid = 0; s0_axi_wvalid = 0; end
        m0_axi_bvalid = 1; m0_axi_bresp = resp;
        #1;
        check_eq("cont_bvalid_win", win1 ? s1_axi_bvalid : s0_axi_bvalid, 1);
        check_eq("cont_bresp_win", win1 ? s1_axi_bresp : s0_axi_bresp, resp);
        check_eq("cont_bvalid_lose", win1 ? s0_axi_bvalid : s1_axi_bvalid, 0);
        @(negedge axi_aclk);
        m0_axi_bvalid = 0;
        if (win1) begin s1_axi_awvalid = 1; s1_axi_wvalid = 1; end
        else      begin s0_axi_awvalid = 1; s0_axi_wvalid = 1; end
    endtask

    initial begin
        // Reset state with every input active
        clear_inputs();
        axi_aresetn = 1'b0;
        s0_axi_awaddr = 8'hAA; s0_axi_awvalid = 1; s0_axi_wvalid = 1; s0_axi_wdata = 32'h1111_2222;
        s0_axi_araddr = 8'h55; s0_axi_arvalid = 1; s0_axi_bready = 1; s0_axi_rready = 1;
        m0_axi_awready = 1; m0_axi_wready = 1; m0_axi_arready = 1; m0_axi_bvalid = 1; m0_axi_rvalid = 1;
        repeat (2) @(negedge axi_aclk);
        #1;
        check_eq("rst_m0_awvalid", m0_axi_awvalid, 0);
        check_eq("rst_m0_wvalid", m0_axi_wvalid, 0);
        check_eq("rst_m0_arvalid", m0_axi_arvalid, 0);
        check_eq("rst_m0_awaddr", m0_axi_awaddr, 0);
        check_eq("rst_m0_wdata", m0_axi_wdata, 0);
        check_eq("rst_m0_araddr", m0_axi_araddr, 0);
        check_eq("rst_m0_bready", m0_axi_bready, 0);
        check_eq("rst_m0_rready", m0_axi_rready, 0);
        check_eq("rst_s0_awready", s0_axi_awready, 0);
        check_eq("rst_s0_bvalid", s0_axi_bvalid, 0);
        check_eq("rst_s0_rvalid", s0_axi_rvalid, 0);
        do_reset();

        // Single s0 write
        @(negedge axi_aclk);
        s0_axi_awaddr = 8'h04; s0_axi_awvalid = 1; s0_axi_wdata = 32'hDEAD_BEEF;
        s0_axi_wstrb = 5'h1F; s0_axi_wvalid = 1; s0_axi_bready = 1; s1_axi_bready = 1;
        m0_axi_awready = 1; m0_axi_wready = 1;
        #1;
        check_eq("wr1_idle_awvalid", m0_axi_awvalid, 0);
        @(negedge axi_aclk);
        #1;
        check_eq("wr1_awaddr", m0_axi_awaddr, 8'h04);
        check_eq("wr1_wdata", m0_axi_wdata, 32'hDEAD_BEEF);
        check_eq("wr1_wstrb", m0_axi_wstrb, 5'h1F);
        check_eq("wr1_awvalid", m0_axi_awvalid, 1);
        check_eq("wr1_wvalid", m0_axi_wvalid, 1);
        check_eq("wr1_s0_awready", s0_axi_awready, 1);
        check_eq("wr1_s0_wready", s0_axi_wready, 1);
        check_eq("wr1_s1_awready", s1_axi_awready, 0);
        check_eq("wr1_s1_wready", s1_axi_wready, 0);
        @(negedge axi_aclk);
        s0_axi_awvalid = 0; s0_axi_wvalid = 0;
        m0_axi_bvalid = 1; m0_axi_bresp = 3'd0;
        #1;
        check_eq("wr1_s0_bvalid", s0_axi_bvalid, 1);
        check_eq("wr1_s0_bresp", s0_axi_bresp, 0);
        check_eq("wr1_s1_bvalid", s1_axi_bvalid, 0);
        check_eq("wr1_m0_bready", m0_axi_bready, 1);
        check_eq("wr1_resp_awvalid", m0_axi_awvalid, 0);
        @(negedge axi_aclk);
        m0_axi_bvalid = 0;
        #1;
        check_eq("wr1_s0_bvalid_end", s0_axi_bvalid, 0);

        // Contention after reset: s0, s1, s0, s1
        do_reset();
        s0_axi_awaddr = 8'h10; s0_axi_wdata = 32'h0000_0010; s0_axi_wstrb = 5'h1F;
        s0_axi_awvalid = 1; s0_axi_wvalid = 1; s0_axi_bready = 1;
        s1_axi_awaddr = 8'h20; s1_axi_wdata = 32'h0000_0020; s1_axi_wstrb = 5'h0F;
        s1_axi_awvalid = 1; s1_axi_wvalid = 1; s1_axi_bready = 1;
        m0_axi_awready = 1; m0_axi_wready = 1;
        wr_contend(1'b0, 3'd1);
        wr_contend(1'b1, 3'd2);
        wr_contend(1'b0, 3'd3);
        wr_contend(1'b1, 3'd0);
        clear_inputs();

        // s1 read, data returned a few cycles after the AR handshake
        @(negedge axi_aclk);
        s1_axi_araddr = 8'h18; s1_axi_arvalid = 1; s1_axi_rready = 1; s0_axi_rready = 1;
        m0_axi_arready = 1;
        @(negedge axi_aclk);
        #1;
        check_eq("rd_araddr", m0_axi_araddr, 8'h18);
        check_eq("rd_arvalid", m0_axi_arvalid, 1);
        check_eq("rd_s1_arready", s1_axi_arready, 1);
        check_eq("rd_s0_arready", s0_axi_arready, 0);
        @(negedge axi_aclk);
        s1_axi_arvalid = 0;
        #1;
        check_eq("rd_wait_rvalid", s1_axi_rvalid, 0);
        check_eq("rd_m0_rready", m0_axi_rready, 1);
        check_eq("rd_wait_arvalid", m0_axi_arvalid, 0);
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        m0_axi_rvalid = 1; m0_axi_rdata = 32'h1234_5678; m0_axi_rresp = 3'd0;
        #1;
        check_eq("rd_s1_rvalid", s1_axi_rvalid, 1);
        check_eq("rd_s1_rdata", s1_axi_rdata, 32'h1234_5678);
        check_eq("rd_s1_rresp", s1_axi_rresp, 0);
        check_eq("rd_s0_rvalid", s0_axi_rvalid, 0);
        @(negedge axi_aclk);
        m0_axi_rvalid = 0;
        #1;
        check_eq("rd_s1_rvalid_end", s1_axi_rvalid, 0);
        clear_inputs();

        // W arrives ready two cycles before AW
        @(negedge axi_aclk);
        aw_base = aw_hs_cnt; w_base = w_hs_cnt;
        s0_axi_awaddr = 8'h08; s0_axi_wdata = 32'h0BAD_F00D; s0_axi_wstrb = 5'h03;
        s0_axi_awvalid = 1; s0_axi_wvalid = 1; s0_axi_bready = 1;
        m0_axi_wready = 1;
        @(negedge axi_aclk);
        #1;
        check_eq("wf_wvalid", m0_axi_wvalid, 1);
        check_eq("wf_s0_wready", s0_axi_wready, 1);
        check_eq("wf_s0_awready", s0_axi_awready, 0);
        @(negedge axi_aclk);
        #1;
        check_eq("wf_no_dup_wvalid", m0_axi_wvalid, 0);
        check_eq("wf_no_dup_wready", s0_axi_wready, 0);
        check_eq("wf_awvalid_held", m0_axi_awvalid, 1);
        @(negedge axi_aclk);
        m0_axi_awready = 1;
        #1;
        check_eq("wf_no_dup_wvalid2", m0_axi_wvalid, 0);
        check_eq("wf_s0_awready_late", s0_axi_awready, 1);
        @(negedge axi_aclk);
        s0_axi_awvalid = 0; s0_axi_wvalid = 0;
        m0_axi_bvalid = 1; m0_axi_bresp = 3'd2;
        #1;
        check_eq("wf_resp_awvalid", m0_axi_awvalid, 0);
        check_eq("wf_s0_bvalid", s0_axi_bvalid, 1);
        check_eq("wf_s0_bresp", s0_axi_bresp, 3'd2);
        check_eq("wf_aw_hs_count", aw_hs_cnt - aw_base, 1);
        check_eq("wf_w_hs_count", w_hs_cnt - w_base, 1);
        @(negedge axi_aclk);
        clear_inputs();

        // Concurrent s0 write and s1 read
        @(negedge axi_aclk);
        s0_axi_awaddr = 8'h30; s0_axi_wdata = 32'hA5A5_A5A5; s0_axi_wstrb = 5'h1F;
        s0_axi_awvalid = 1; s0_axi_wvalid = 1; s0_axi_bready = 1; s0_axi_rready = 1;
        s1_axi_araddr = 8'h3C; s1_axi_arvalid = 1; s1_axi_rready = 1; s1_axi_bready = 1;
        m0_axi_awready = 1; m0_axi_wready = 1; m0_axi_arready = 1;
        @(negedge axi_aclk);
        #1;
        check_eq("cc_awaddr", m0_axi_awaddr, 8'h30);
        check_eq("cc_araddr", m0_axi_araddr, 8'h3C);
        check_eq("cc_s0_awready", s0_axi_awready, 1);
        check_eq("cc_s1_arready", s1_axi_arready, 1);
        check_eq("cc_s1_awready", s1_axi_awready, 0);
        @(negedge axi_aclk);
        s0_axi_awvalid = 0; s0_axi_wvalid = 0; s1_axi_arvalid = 0;
        m0_axi_bvalid = 1; m0_axi_bresp = 3'd0;
        m0_axi_rvalid = 1; m0_axi_rdata = 32'hCAFE_0001; m0_axi_rresp = 3'd1;
        #1;
        check_eq("cc_s0_bvalid", s0_axi_bvalid, 1);
        check_eq("cc_s1_bvalid", s1_axi_bvalid, 0);
        check_eq("cc_s1_rvalid", s1_axi_rvalid, 1);
        check_eq("cc_s0_rvalid", s0_axi_rvalid, 0);
        check_eq("cc_s1_rdata", s1_axi_rdata, 32'hCAFE_0001);
        check_eq("cc_s1_rresp", s1_axi_rresp, 3'd1);
        @(negedge axi_aclk);
        clear_inputs();

        // Reset while in W_RESP with bvalid high
        @(negedge axi_aclk);
        s0_axi_awaddr = 8'h40; s0_axi_awvalid = 1; s0_axi_wvalid = 1; s0_axi_bready = 1;
        m0_axi_awready = 1; m0_axi_wready = 1;
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        s0_axi_awvalid = 0; s0_axi_wvalid = 0;
        m0_axi_bvalid = 1;
        #1;
        check_eq("rr_pre_s0_bvalid", s0_axi_bvalid, 1);
        check_eq("rr_pre_m0_bready", m0_axi_bready, 1);
        axi_aresetn = 1'b0;
        #1;
        check_eq("rr_m0_bready", m0_axi_bready, 0);
        check_eq("rr_s0_bvalid", s0_axi_bvalid, 0);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        m0_axi_bvalid = 0;
        s0_axi_awaddr = 8'h50; s0_axi_awvalid = 1; s0_axi_wvalid = 1;
        s1_axi_awaddr = 8'h60; s1_axi_awvalid = 1; s1_axi_wvalid = 1; s1_axi_bready = 1;
        @(negedge axi_aclk);
        #1;
        check_eq("rr_tie_awaddr", m0_axi_awaddr, 8'h50);
        check_eq("rr_tie_s0_awready", s0_axi_awready, 1);
        check_eq("rr_tie_s1_awready", s1_axi_awready, 0);
        clear_inputs();
        @(negedge axi_aclk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
